// File: rtl/params_pkg.sv
// Shared widths and the redirect FSM/kind types used by the redirect unit and its target calculator.
package params_pkg;

  localparam int ADDR_WIDTH = 6;
  localparam int MEM_SIZE   = 64;

  typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_HOLD} redirect_state_t;
  typedef enum logic {RD_JUMP, RD_BRANCH} redirect_kind_t;

endpackage

// File: rtl/redirect_target_calc.sv
// Combinational target calculation: wrapped PC-relative branch target and modulo jump target.
module redirect_target_calc
  import params_pkg::*;
#(
  parameter int ADDR_WIDTH   = params_pkg::ADDR_WIDTH,
  parameter int MEM_SIZE     = params_pkg::MEM_SIZE,
  parameter int OFFSET_WIDTH = 12
) (
  input  logic [ADDR_WIDTH-1:0]   ex_pc_i,
  input  logic [OFFSET_WIDTH-1:0] ex_offset_i,
  input  logic [ADDR_WIDTH-1:0]   jump_target_i,
  output logic [ADDR_WIDTH-1:0]   branch_target_o,
  output logic [ADDR_WIDTH-1:0]   jump_target_o
);

  // Wide enough that pc + 1 + offset can never overflow before the modulo is applied.
  localparam int SUM_W = ((ADDR_WIDTH > OFFSET_WIDTH) ? ADDR_WIDTH : OFFSET_WIDTH) + 2;
  localparam logic signed [SUM_W-1:0] MEM_S = SUM_W'(MEM_SIZE);
  localparam logic signed [SUM_W-1:0] ONE_S = SUM_W'(1);
  localparam logic [ADDR_WIDTH:0]     MEM_U = (ADDR_WIDTH + 1)'(MEM_SIZE);

  logic signed [SUM_W-1:0] pc_ext;
  logic signed [SUM_W-1:0] off_ext;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] rem;

  always_comb begin
    pc_ext  = signed'({{(SUM_W - ADDR_WIDTH){1'b0}}, ex_pc_i});
    off_ext = signed'({{(SUM_W - OFFSET_WIDTH){ex_offset_i[OFFSET_WIDTH-1]}}, ex_offset_i});
    sum     = pc_ext + off_ext + ONE_S;
    // Signed remainder keeps the dividend's sign, so a negative result is lifted by one MEM_SIZE.
    rem     = sum % MEM_S;
    if (rem < 0) begin
      rem = rem + MEM_S;
    end
    branch_target_o = ADDR_WIDTH'(rem);
    jump_target_o   = ADDR_WIDTH'({1'b0, jump_target_i} % MEM_U);
  end

endmodule

// File: rtl/redirect_unit.sv
// Arbitrates decode jumps and execute branches into one registered fetch redirect with squash/epoch.
// Optional statistics counters are built when REDIRECT_STATS_EN is defined.
module redirect_unit
  import params_pkg::*;
#(
  parameter int ADDR_WIDTH   = params_pkg::ADDR_WIDTH,
  parameter int MEM_SIZE     = params_pkg::MEM_SIZE,
  parameter int OFFSET_WIDTH = 12
`ifdef REDIRECT_STATS_EN
  ,
  parameter int STAT_WIDTH   = 16
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dec_jump_valid_i,
  input  logic [ADDR_WIDTH-1:0]   dec_jump_target_i,
  input  logic                    ex_branch_valid_i,
  input  logic                    ex_branch_taken_i,
  input  logic [ADDR_WIDTH-1:0]   ex_pc_i,
  input  logic [OFFSET_WIDTH-1:0] ex_offset_i,
  input  logic                    fetch_ready_i,
  output logic                    is_jump_o,
  output logic [ADDR_WIDTH-1:0]   jump_address_o,
  output logic                    alu_branch_taken_o,
  output logic [ADDR_WIDTH-1:0]   pc_branch_offset_o,
  output logic                    squash_o,
  output logic                    epoch_o,
  output logic                    busy_o
`ifdef REDIRECT_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]   stat_jumps_o,
  output logic [STAT_WIDTH-1:0]   stat_branches_o,
  output logic [STAT_WIDTH-1:0]   stat_hold_cycles_o
`endif
);

  redirect_state_t        state_q, state_d;
  redirect_kind_t         kind_q, kind_d;
  logic [ADDR_WIDTH-1:0]  target_q, target_d;
  logic                   epoch_q, epoch_d;
  logic                   is_jump_q, is_jump_d;
  logic                   br_taken_q, br_taken_d;
  logic [ADDR_WIDTH-1:0]  jump_address_q, jump_address_d;
  logic [ADDR_WIDTH-1:0]  pc_branch_q, pc_branch_d;
  logic                   accept;
  logic                   branch_req;
  logic                   jump_req;
  logic [ADDR_WIDTH-1:0]  branch_target;
  logic [ADDR_WIDTH-1:0]  jump_target;

  redirect_target_calc #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .MEM_SIZE    (MEM_SIZE),
    .OFFSET_WIDTH(OFFSET_WIDTH)
  ) u_target_calc (
    .ex_pc_i        (ex_pc_i),
    .ex_offset_i    (ex_offset_i),
    .jump_target_i  (dec_jump_target_i),
    .branch_target_o(branch_target),
    .jump_target_o  (jump_target)
  );

  assign branch_req = ex_branch_valid_i && ex_branch_taken_i;
  assign jump_req   = dec_jump_valid_i;

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    target_d = target_q;
    epoch_d  = epoch_q;
    accept   = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (branch_req) begin
          kind_d   = RD_BRANCH;
          target_d = branch_target;
          state_d  = RD_ISSUE;
        end else if (jump_req) begin
          kind_d   = RD_JUMP;
          target_d = jump_target;
          state_d  = RD_ISSUE;
        end
      end
      RD_ISSUE, RD_HOLD: begin
        // An older taken branch overrides a pending jump even if fetch is ready: the jump is wrong-path.
        if (kind_q == RD_JUMP && branch_req) begin
          kind_d   = RD_BRANCH;
          target_d = branch_target;
          state_d  = RD_ISSUE;
        end else if (fetch_ready_i) begin
          accept   = 1'b1;
          epoch_d  = ~epoch_q;
          state_d  = RD_IDLE;
        end else begin
          state_d  = RD_HOLD;
        end
      end
      default: state_d = RD_IDLE;
    endcase
    is_jump_d      = (state_d != RD_IDLE) && (kind_d == RD_JUMP);
    br_taken_d     = (state_d != RD_IDLE) && (kind_d == RD_BRANCH);
    jump_address_d = is_jump_d  ? target_d : '0;
    pc_branch_d    = br_taken_d ? target_d : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= RD_IDLE;
      kind_q         <= RD_JUMP;
      target_q       <= '0;
      epoch_q        <= 1'b0;
      is_jump_q      <= 1'b0;
      br_taken_q     <= 1'b0;
      jump_address_q <= '0;
      pc_branch_q    <= '0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      target_q       <= target_d;
      epoch_q        <= epoch_d;
      is_jump_q      <= is_jump_d;
      br_taken_q     <= br_taken_d;
      jump_address_q <= jump_address_d;
      pc_branch_q    <= pc_branch_d;
    end
  end

  assign is_jump_o          = is_jump_q;
  assign jump_address_o     = jump_address_q;
  assign alu_branch_taken_o = br_taken_q;
  assign pc_branch_offset_o = pc_branch_q;
  assign squash_o           = accept && !rst_i;
  assign epoch_o            = epoch_q;
  assign busy_o             = (state_q != RD_IDLE);

`ifdef REDIRECT_STATS_EN
  logic [STAT_WIDTH-1:0] jumps_q, jumps_d;
  logic [STAT_WIDTH-1:0] branches_q, branches_d;
  logic [STAT_WIDTH-1:0] holds_q, holds_d;

  // Saturating counters: they stop at all-ones instead of wrapping.
  always_comb begin
    jumps_d    = jumps_q;
    branches_d = branches_q;
    holds_d    = holds_q;
    if (accept && kind_q == RD_JUMP && jumps_q != '1) begin
      jumps_d = jumps_q + 1'b1;
    end
    if (accept && kind_q == RD_BRANCH && branches_q != '1) begin
      branches_d = branches_q + 1'b1;
    end
    if (state_q == RD_HOLD && holds_q != '1) begin
      holds_d = holds_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      jumps_q    <= '0;
      branches_q <= '0;
      holds_q    <= '0;
    end else begin
      jumps_q    <= jumps_d;
      branches_q <= branches_d;
      holds_q    <= holds_d;
    end
  end

  assign stat_jumps_o       = jumps_q;
  assign stat_branches_o    = branches_q;
  assign stat_hold_cycles_o = holds_q;
`endif

endmodule

// File: tb/tb_redirect_unit.sv
// Self-checking bench for redirect_unit: directed scenarios then randomized traffic against a
// transaction-level model. Stats checks are compiled in when REDIRECT_STATS_EN is defined.
module tb_redirect_unit;

  localparam int AW = 6;
  localparam int MS = 64;
  localparam int OW = 12;

  logic          clk;
  logic          rst;
  logic          dec_jump_valid;
  logic [AW-1:0] dec_jump_target;
  logic          ex_branch_valid;
  logic          ex_branch_taken;
  logic [AW-1:0] ex_pc;
  logic [OW-1:0] ex_offset;
  logic          fetch_ready;
  logic          is_jump;
  logic [AW-1:0] jump_address;
  logic          alu_branch_taken;
  logic [AW-1:0] pc_branch_offset;
  logic          squash;
  logic          epoch;
  logic          busy;
`ifdef REDIRECT_STATS_EN
  logic [15:0]   stat_jumps;
  logic [15:0]   stat_branches;
  logic [15:0]   stat_hold_cycles;
`endif

  redirect_unit #(
    .ADDR_WIDTH  (AW),
    .MEM_SIZE    (MS),
    .OFFSET_WIDTH(OW)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .dec_jump_valid_i  (dec_jump_valid),
    .dec_jump_target_i (dec_jump_target),
    .ex_branch_valid_i (ex_branch_valid),
    .ex_branch_taken_i (ex_branch_taken),
    .ex_pc_i           (ex_pc),
    .ex_offset_i       (ex_offset),
    .fetch_ready_i     (fetch_ready),
    .is_jump_o         (is_jump),
    .jump_address_o    (jump_address),
    .alu_branch_taken_o(alu_branch_taken),
    .pc_branch_offset_o(pc_branch_offset),
    .squash_o          (squash),
    .epoch_o           (epoch),
    .busy_o            (busy)
`ifdef REDIRECT_STATS_EN
    ,
    .stat_jumps_o      (stat_jumps),
    .stat_branches_o   (stat_branches),
    .stat_hold_cycles_o(stat_hold_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  // reference model: one pending redirect (or none), described by kind and absolute target
  bit mPending = 0;
  bit mIsJump = 0;
  int mTarget = 0;
  bit mEpoch = 0;
  bit mWaited = 0;
  int mJumps = 0;
  int mBranches = 0;
  int mHolds = 0;

  // stimulus of the current cycle, as driven by the bench
  bit sJv, sBv, sBt, sRdy, sRst;
  int sJt, sPc, sOff;

  function automatic int branchTarget(input int pc, input int off);
    int s;
    s = (pc + 1 + off) % MS;
    if (s < 0) s = s + MS;
    return s;
  endfunction

  function automatic int satInc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // drive one cycle of inputs, then compare every output with the model before the next edge
  task automatic applyStimulus(input bit jv, input int jt, input bit bv, input bit bt,
                               input int pc, input int off, input bit rdy, input bit rs);
    bit expSquash;
    sJv = jv; sJt = jt; sBv = bv; sBt = bt; sPc = pc; sOff = off; sRdy = rdy; sRst = rs;
    dec_jump_valid  = jv;
    dec_jump_target = AW'(jt);
    ex_branch_valid = bv;
    ex_branch_taken = bt;
    ex_pc           = AW'(pc);
    ex_offset       = OW'(off);
    fetch_ready     = rdy;
    rst             = rs;
    #3;
    expSquash = mPending && rdy && !rs && !(mIsJump && bv && bt);
    checkOutput("is_jump", 32'(is_jump), 32'(mPending && mIsJump));
    checkOutput("jump_address", 32'(jump_address), (mPending && mIsJump) ? 32'(mTarget) : 32'd0);
    checkOutput("alu_branch_taken", 32'(alu_branch_taken), 32'(mPending && !mIsJump));
    checkOutput("pc_branch_offset", 32'(pc_branch_offset), (mPending && !mIsJump) ? 32'(mTarget) : 32'd0);
    checkOutput("squash", 32'(squash), 32'(expSquash));
    checkOutput("epoch", 32'(epoch), 32'(mEpoch));
    checkOutput("busy", 32'(busy), 32'(mPending));
`ifdef REDIRECT_STATS_EN
    checkOutput("stat_jumps", 32'(stat_jumps), 32'(mJumps));
    checkOutput("stat_branches", 32'(stat_branches), 32'(mBranches));
    checkOutput("stat_hold_cycles", 32'(stat_hold_cycles), 32'(mHolds));
`endif
  endtask

  // advance through the clock edge and let the model take the same step
  task automatic endCycle();
    @(posedge clk);
    if (sRst) begin
      mPending = 0; mIsJump = 0; mTarget = 0; mEpoch = 0; mWaited = 0;
      mJumps = 0; mBranches = 0; mHolds = 0;
    end else if (!mPending) begin
      mWaited = 0;
      if (sBv && sBt) begin
        mPending = 1; mIsJump = 0; mTarget = branchTarget(sPc, sOff);
      end else if (sJv) begin
        mPending = 1; mIsJump = 1; mTarget = sJt % MS;
      end
    end else begin
      if (mWaited) mHolds = satInc(mHolds);
      if (mIsJump && sBv && sBt) begin
        mIsJump = 0; mTarget = branchTarget(sPc, sOff); mWaited = 0;
      end else if (sRdy) begin
        if (mIsJump) mJumps = satInc(mJumps);
        else mBranches = satInc(mBranches);
        mPending = 0; mEpoch = !mEpoch; mWaited = 0;
      end else begin
        mWaited = 1;
      end
    end
    #1;
  endtask

  task automatic idleCycle(input bit rdy);
    applyStimulus(0, 0, 0, 0, 0, 0, rdy, 0);
  endtask

  initial begin
    rst = 1'b1;
    dec_jump_valid = 0; dec_jump_target = '0; ex_branch_valid = 0; ex_branch_taken = 0;
    ex_pc = '0; ex_offset = '0; fetch_ready = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    idleCycle(0); endCycle();

    // branch with fetch ready
    applyStimulus(0, 0, 1, 1, 10, 5, 1, 0); endCycle();
    idleCycle(1);
    checkOutput("t1_branch_taken", 32'(alu_branch_taken), 32'd1);
    checkOutput("t1_target", 32'(pc_branch_offset), 32'd16);
    checkOutput("t1_squash", 32'(squash), 32'd1);
    endCycle();
    idleCycle(1);
    checkOutput("t1_epoch", 32'(epoch), 32'd1);
    endCycle();

    // backward wrap
    applyStimulus(0, 0, 1, 1, 2, -10, 1, 0); endCycle();
    idleCycle(1);
    checkOutput("t2_target", 32'(pc_branch_offset), 32'd57);
    endCycle();

    // simultaneous branch and jump
    applyStimulus(1, 40, 1, 1, 20, 3, 1, 0); endCycle();
    idleCycle(1);
    checkOutput("t3_is_jump", 32'(is_jump), 32'd0);
    checkOutput("t3_target", 32'(pc_branch_offset), 32'd24);
    endCycle();

    // held jump replaced by a taken branch
    applyStimulus(1, 33, 0, 0, 0, 0, 0, 0); endCycle();
    for (int i = 0; i < 3; i++) begin
      idleCycle(0);
      checkOutput("t4_hold_address", 32'(jump_address), 32'd33);
      endCycle();
    end
    applyStimulus(0, 0, 1, 1, 5, 1, 1, 0);
    checkOutput("t4_replace_no_squash", 32'(squash), 32'd0);
    endCycle();
    idleCycle(1);
    checkOutput("t4_target", 32'(pc_branch_offset), 32'd7);
    checkOutput("t4_squash", 32'(squash), 32'd1);
    endCycle();
    idleCycle(0); endCycle();

    // not-taken branch, then reset while holding
    applyStimulus(0, 0, 1, 0, 7, 3, 1, 0); endCycle();
    idleCycle(1);
    checkOutput("t5_not_taken_busy", 32'(busy), 32'd0);
    endCycle();
    applyStimulus(1, 2, 0, 0, 0, 0, 0, 0); endCycle();
    idleCycle(1); endCycle();
    applyStimulus(1, 12, 0, 0, 0, 0, 0, 0); endCycle();
    idleCycle(0); endCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("t5_reset_squash", 32'(squash), 32'd0);
    endCycle();
    idleCycle(0);
    checkOutput("t5_reset_busy", 32'(busy), 32'd0);
    checkOutput("t5_reset_epoch", 32'(epoch), 32'd0);
    checkOutput("t5_reset_jump_address", 32'(jump_address), 32'd0);
    endCycle();

`ifdef REDIRECT_STATS_EN
    // 2 jumps, 3 branches, 4 hold cycles
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1); endCycle();
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0); endCycle();
    idleCycle(1); endCycle();
    applyStimulus(1, 9, 0, 0, 0, 0, 0, 0); endCycle();
    idleCycle(0); endCycle();
    idleCycle(0); endCycle();
    idleCycle(1); endCycle();
    applyStimulus(0, 0, 1, 1, 30, -4, 0, 0); endCycle();
    idleCycle(0); endCycle();
    idleCycle(0); endCycle();
    idleCycle(1); endCycle();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 1, 1, i, 8, 0, 0); endCycle();
      idleCycle(1); endCycle();
    end
    idleCycle(0);
    checkOutput("t6_jumps", 32'(stat_jumps), 32'd2);
    checkOutput("t6_branches", 32'(stat_branches), 32'd3);
    checkOutput("t6_holds", 32'(stat_hold_cycles), 32'd4);
    endCycle();
`endif

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      int off;
      if ($urandom_range(0, 3) == 0) off = int'($urandom_range(0, 4095)) - 2048;
      else off = int'($urandom_range(0, 40)) - 20;
      applyStimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, MS - 1)),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, MS - 1)), off,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0);
      endCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
